// File: rtl/floo_mcast_xy_router.sv
// floo_mcast_xy_router: 5-port XY mesh router with mask-based multicast fork and per-input FIFOs.
// Define FLOO_ROUTER_MCAST_EN for multicast routing; otherwise masks are ignored (unicast XY).
module floo_mcast_xy_router #(
  parameter int unsigned NumX        = 4,
  parameter int unsigned NumY        = 4,
  parameter int unsigned XId         = 0,
  parameter int unsigned YId         = 0,
  parameter int unsigned XW          = 3,
  parameter int unsigned YW          = 3,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned InFifoDepth = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [4:0]                         valid_i,
  output logic [4:0]                         ready_o,
  input  logic [5*(DataWidth+2*XW+2*YW)-1:0] data_i,
  output logic [4:0]                         valid_o,
  input  logic [4:0]                         ready_i,
  output logic [5*(DataWidth+2*XW+2*YW)-1:0] data_o,
  output logic                               drop_o
);

  localparam int unsigned FW = DataWidth + 2*XW + 2*YW;
  localparam int unsigned PW = (InFifoDepth > 1) ? $clog2(InFifoDepth) : 1;
  localparam int unsigned CW = $clog2(InFifoDepth + 1);
  localparam int unsigned PortL = 0;
  localparam int unsigned PortN = 1;
  localparam int unsigned PortE = 2;
  localparam int unsigned PortS = 3;
  localparam int unsigned PortW = 4;
  localparam logic [XW-1:0] XSelf = XW'(XId);
  localparam logic [YW-1:0] YSelf = YW'(YId);

  if (XId >= NumX || YId >= NumY || InFifoDepth < 2) begin : g_param_check
    $error("floo_mcast_xy_router: coordinates outside mesh or FIFO depth below 2");
  end

  function automatic logic [4:0] route_of(input int unsigned port,
                                          input logic [XW-1:0] dx, input logic [YW-1:0] dy,
                                          input logic [XW-1:0] mx, input logic [YW-1:0] my);
    logic [XW-1:0] minx, maxx;
    logic [YW-1:0] miny, maxy;
    logic          cm, rm;
    minx = dx & ~mx;
    maxx = dx | mx;
    miny = dy & ~my;
    maxy = dy | my;
    cm   = (XSelf & ~mx) == minx;
    rm   = (YSelf & ~my) == miny;
    route_of        = '0;
    route_of[PortE] = (port == PortL || port == PortW) && (maxx > XSelf);
    route_of[PortW] = (port == PortL || port == PortE) && (minx < XSelf);
    route_of[PortN] = cm && (port != PortN) && (maxy > YSelf);
    route_of[PortS] = cm && (port != PortS) && (miny < YSelf);
    route_of[PortL] = cm && rm && (port != PortL);
  endfunction

  logic              init_q;
  logic [FW-1:0]     mem [5][InFifoDepth];
  logic [PW-1:0]     rd_ptr [5];
  logic [PW-1:0]     wr_ptr [5];
  logic [CW-1:0]     count  [5];
  logic [4:0]        sent   [5];
  logic [FW-1:0]     head   [5];
  logic [4:0]        route  [5];
  logic [4:0]        gnt_to [5];
  logic [2:0]        gnt_idx[5];
  logic [2:0]        rr_ptr [5];
  logic [FW-1:0]     out_data_q[5];
  logic [4:0]        head_valid, push, pop, drop, gnt_any, out_valid_q;
  logic              drop_q;

  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      head[i]       = mem[i][rd_ptr[i]];
      head_valid[i] = count[i] != '0;
      ready_o[i]    = init_q && (count[i] != CW'(InFifoDepth));
      push[i]       = valid_i[i] && ready_o[i];
`ifdef FLOO_ROUTER_MCAST_EN
      route[i] = route_of(i, head[i][0 +: XW], head[i][XW +: YW],
                          head[i][XW+YW +: XW], head[i][2*XW+YW +: YW]);
`else
      route[i] = route_of(i, head[i][0 +: XW], head[i][XW +: YW], '0, '0);
`endif
    end
  end

  // Round-robin per output: scanning from lowest to highest priority lets the
  // last hit (the input closest to rr_ptr) win.
  always_comb begin : arb_comb
    int unsigned cand;
    cand = 0;
    for (int unsigned o = 0; o < 5; o++) begin
      gnt_any[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int unsigned k = 5; k > 0; k--) begin
        cand = (32'(rr_ptr[o]) + k - 1) % 5;
        if ((!out_valid_q[o] || ready_i[o]) && head_valid[cand] &&
            route[cand][o] && !sent[cand][o]) begin
          gnt_any[o] = 1'b1;
          gnt_idx[o] = 3'(cand);
        end
      end
    end
    for (int unsigned i = 0; i < 5; i++) begin
      gnt_to[i] = '0;
      for (int unsigned o = 0; o < 5; o++)
        gnt_to[i][o] = gnt_any[o] && (gnt_idx[o] == 3'(i));
      // Head leaves once every routed output has been served, now or earlier.
      pop[i]  = head_valid[i] && ((route[i] & ~sent[i] & ~gnt_to[i]) == '0);
      drop[i] = head_valid[i] && (route[i] == '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_q      <= 1'b0;
      drop_q      <= 1'b0;
      out_valid_q <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        rd_ptr[i]     <= '0;
        wr_ptr[i]     <= '0;
        count[i]      <= '0;
        sent[i]       <= '0;
        rr_ptr[i]     <= '0;
        out_data_q[i] <= '0;
      end
    end else begin
      init_q <= 1'b1;
      drop_q <= |drop;
      for (int unsigned i = 0; i < 5; i++) begin
        if (push[i])
          wr_ptr[i] <= (wr_ptr[i] == PW'(InFifoDepth - 1)) ? '0 : wr_ptr[i] + 1'b1;
        if (pop[i])
          rd_ptr[i] <= (rd_ptr[i] == PW'(InFifoDepth - 1)) ? '0 : rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
        sent[i]  <= pop[i] ? '0 : (sent[i] | gnt_to[i]);
      end
      for (int unsigned o = 0; o < 5; o++) begin
        if (gnt_any[o]) begin
          out_valid_q[o] <= 1'b1;
          out_data_q[o]  <= head[gnt_idx[o]];
          rr_ptr[o]      <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
        end else if (ready_i[o]) begin
          out_valid_q[o] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < 5; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= data_i[i*FW +: FW];
  end

  always_comb begin
    for (int unsigned o = 0; o < 5; o++)
      data_o[o*FW +: FW] = out_data_q[o];
  end

  assign valid_o = out_valid_q;
  assign drop_o  = drop_q;

endmodule

// File: tb/tb_floo_mcast_xy_router.sv
// Directed bench for floo_mcast_xy_router at tile (1,1); expectations follow FLOO_ROUTER_MCAST_EN.
module tb_floo_mcast_xy_router;

  localparam int DW = 16;
  localparam int FW = DW + 12;
`ifdef FLOO_ROUTER_MCAST_EN
  localparam logic [4:0] BcastMask = 5'b11110;
`else
  localparam logic [4:0] BcastMask = 5'b10000;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      valid_i, ready_o, valid_o, ready_i;
  logic [5*FW-1:0] data_i_s, data_o;
  logic            drop_o;

  int checks = 0;
  int errors = 0;
  int deliv[5] = '{default: 0};
  int drop_cnt = 0;
  logic [FW-1:0] east_log[$];

  floo_mcast_xy_router #(
    .NumX(4), .NumY(4), .XId(1), .YId(1), .XW(3), .YW(3),
    .DataWidth(DW), .InFifoDepth(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i_s),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      for (int o = 0; o < 5; o++)
        if (valid_o[o] && ready_i[o]) begin
          deliv[o]++;
          if (o == 2) east_log.push_back(data_o[2*FW +: FW]);
        end
      if (drop_o) drop_cnt++;
    end
  end

  function automatic logic [FW-1:0] mk(input logic [2:0] dx, input logic [2:0] dy,
                                       input logic [2:0] mx, input logic [2:0] my,
                                       input logic [DW-1:0] p);
    return {p, my, mx, dy, dx};
  endfunction

  function automatic logic [FW-1:0] dout(input int p);
    return data_o[p*FW +: FW];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge after the handshake edge.
  task automatic send(input int p, input logic [FW-1:0] f);
    check($sformatf("send_ready%0d", p), 64'(ready_o[p]), 64'd1);
    valid_i[p] = 1'b1;
    data_i_s[p*FW +: FW] = f;
    tick();
    valid_i[p] = 1'b0;
  endtask

  initial begin
    logic [FW-1:0] a, b, f, g, l0, l1, w0, w1;
    logic [4:0] bm;
    int base[5];
    int nlog, tot;
    bm = BcastMask;
    rst = 1'b1; valid_i = '0; ready_i = '1; data_i_s = '0;
    repeat (2) tick();
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_drop", 64'(drop_o), 64'd0);
    rst = 1'b0;
    #1 check("ready_before_edge", 64'(ready_o), 64'd0);
    tick();
    check("ready_after_rst", 64'(ready_o), 64'h1f);

    // Unicast east with exact two-cycle latency
    a = mk(3, 1, 0, 0, 16'hA001);
    send(0, a);
    check("lat_t1_valid", 64'(valid_o), 64'd0);
    tick();
    check("lat_t2_valid", 64'(valid_o), 64'b00100);
    check("lat_t2_data", 64'(dout(2)), 64'(a));
    tick();
    check("lat_t3_valid", 64'(valid_o), 64'd0);

    f = mk(1, 1, 0, 0, 16'hB002);
    send(4, f); tick();
    check("west_to_local_valid", 64'(valid_o), 64'b00001);
    check("west_to_local_data", 64'(dout(0)), 64'(f));
    tick();
    g = mk(1, 3, 0, 0, 16'hC003);
    send(3, g); tick();
    check("south_to_north_valid", 64'(valid_o), 64'b00010);
    check("south_to_north_data", 64'(dout(1)), 64'(g));
    tick();

    // Broadcast from Local, no backpressure
    base = deliv;
    b = mk(0, 0, 3, 3, 16'hD004);
    send(0, b);
    check("bc_ready_local_t1", 64'(ready_o[0]), 64'd1);
    tick();
    check("bc_valid", 64'(valid_o), 64'(bm));
    check("bc_data_w", 64'(dout(4)), 64'(b));
`ifdef FLOO_ROUTER_MCAST_EN
    check("bc_data_n", 64'(dout(1)), 64'(b));
    check("bc_data_e", 64'(dout(2)), 64'(b));
    check("bc_data_s", 64'(dout(3)), 64'(b));
`endif
    check("bc_ready_local_t2", 64'(ready_o[0]), 64'd1);
    tick();
    check("bc_valid_clear", 64'(valid_o), 64'd0);
    for (int o = 0; o < 5; o++)
      check($sformatf("bc_count%0d", o), 64'(deliv[o] - base[o]), 64'(bm[o]));

    // Broadcast while East output is held by an earlier flit
    base = deliv;
    ready_i = 5'b11011;
    a = mk(3, 1, 0, 0, 16'hA005);
    send(0, a); tick();
    check("bp_hold_valid", 64'(valid_o), 64'b00100);
    b = mk(0, 0, 3, 3, 16'hD006);
    send(0, b);
    check("bp_ready_local", 64'(ready_o[0]), 64'd1);
    tick();
    check("bp_fork_valid", 64'(valid_o), 64'(bm | 5'b00100));
    check("bp_fork_data_e", 64'(dout(2)), 64'(a));
    check("bp_fork_data_w", 64'(dout(4)), 64'(b));
    repeat (3) tick();
    check("bp_wait_valid", 64'(valid_o), 64'b00100);
    check("bp_wait_data_e", 64'(dout(2)), 64'(a));
    check("bp_wait_ready_local", 64'(ready_o[0]), 64'd1);
    check("bp_wait_cnt_n", 64'(deliv[1] - base[1]), 64'(bm[1]));
    check("bp_wait_cnt_s", 64'(deliv[3] - base[3]), 64'(bm[3]));
    check("bp_wait_cnt_w", 64'(deliv[4] - base[4]), 64'(bm[4]));
    ready_i = '1;
    tick();
    check("bp_release_valid", 64'(valid_o), 64'({2'b00, bm[2], 2'b00}));
`ifdef FLOO_ROUTER_MCAST_EN
    check("bp_release_data_e", 64'(dout(2)), 64'(b));
`endif
    tick();
    check("bp_done_valid", 64'(valid_o), 64'd0);
    check("bp_cnt_e", 64'(deliv[2] - base[2]), 64'(1 + int'(bm[2])));
    check("bp_cnt_n", 64'(deliv[1] - base[1]), 64'(bm[1]));
    check("bp_cnt_w", 64'(deliv[4] - base[4]), 64'(bm[4]));

    // Local and West contend for East; East pointer sits at 1 after the Local grants above,
    // so West wins first and the winners alternate W, L, W, L.
    nlog = east_log.size();
    ready_i = 5'b11011;
    l0 = mk(3, 1, 0, 0, 16'h1000); w0 = mk(3, 1, 0, 0, 16'h4000);
    l1 = mk(3, 1, 0, 0, 16'h1001); w1 = mk(3, 1, 0, 0, 16'h4001);
    check("rr_ready_l0", 64'(ready_o[0]), 64'd1);
    check("rr_ready_w0", 64'(ready_o[4]), 64'd1);
    valid_i[0] = 1'b1; data_i_s[0 +: FW] = l0;
    valid_i[4] = 1'b1; data_i_s[4*FW +: FW] = w0;
    tick();
    check("rr_ready_l1", 64'(ready_o[0]), 64'd1);
    check("rr_ready_w1", 64'(ready_o[4]), 64'd1);
    data_i_s[0 +: FW] = l1; data_i_s[4*FW +: FW] = w1;
    tick();
    valid_i = '0;
    check("rr_first_valid", 64'(valid_o), 64'b00100);
    check("rr_first_data", 64'(dout(2)), 64'(w0));
    check("rr_local_full", 64'(ready_o[0]), 64'd0);
    check("rr_west_not_full", 64'(ready_o[4]), 64'd1);
    ready_i = '1;
    repeat (5) tick();
    check("rr_drained", 64'(valid_o), 64'd0);
    check("rr_count", 64'(east_log.size() - nlog), 64'd4);
    if (east_log.size() >= nlog + 4) begin
      check("rr_order0", 64'(east_log[nlog]),     64'(w0));
      check("rr_order1", 64'(east_log[nlog + 1]), 64'(l0));
      check("rr_order2", 64'(east_log[nlog + 2]), 64'(w1));
      check("rr_order3", 64'(east_log[nlog + 3]), 64'(l1));
    end

    // Empty route set at self
    base = deliv;
    nlog = drop_cnt;
    send(0, mk(1, 1, 0, 0, 16'hE007));
    check("drop_t1", 64'(drop_o), 64'd0);
    tick();
    check("drop_t2", 64'(drop_o), 64'd1);
    check("drop_no_out", 64'(valid_o), 64'd0);
    tick();
    check("drop_t3", 64'(drop_o), 64'd0);
    check("drop_count", 64'(drop_cnt - nlog), 64'd1);
    tot = 0;
    for (int o = 0; o < 5; o++) tot += deliv[o] - base[o];
    check("drop_nothing_sent", 64'(tot), 64'd0);

    // Asynchronous reset with flits buffered and outputs stalled
    ready_i = '0;
    send(0, mk(3, 1, 0, 0, 16'hF008));
    send(4, mk(1, 1, 0, 0, 16'hF009));
    send(0, mk(3, 1, 0, 0, 16'hF00A));
    check("mid_valid", 64'(valid_o), 64'b00101);
    base = deliv;
    #2 rst = 1'b1;
    #1 check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_ready", 64'(ready_o), 64'd0);
    tick();
    rst = 1'b0;
    ready_i = '1;
    repeat (5) tick();
    check("post_rst_valid", 64'(valid_o), 64'd0);
    check("post_rst_ready", 64'(ready_o), 64'h1f);
    tot = 0;
    for (int o = 0; o < 5; o++) tot += deliv[o] - base[o];
    check("post_rst_nothing_sent", 64'(tot), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
